// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage between the PC register and decode.
// Runs a single-outstanding req/ack fetch and buffers results in a FIFO.
module ifetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  output logic        o_pcwr,
  input  logic        i_flush,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  input  logic        i_id_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CONE = (AW+1)'(1);
  localparam logic [AW-1:0] PONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  logic [AW:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0] r_q_pc  [DEPTH];
  logic [31:0] r_q_ins [DEPTH];

  logic w_wait;
  logic w_push;
  logic w_pop;

  assign w_wait     = (r_state == S_WAIT);
  assign w_push     = w_wait & i_imem_ack & ~i_flush;
  assign o_if_valid = (r_count != '0);
  assign w_pop      = o_if_valid & i_id_ready;
  assign o_pcwr     = i_rst | i_flush | (w_wait & i_imem_ack);
  assign o_if_pc    = o_if_valid ? r_q_pc[r_rptr]  : '0;
  assign o_if_instr = o_if_valid ? r_q_ins[r_rptr] : '0;

  // Fetch FSM: issue from IDLE, keep data in WAIT, discard it in DROP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      o_imem_req  <= 1'b0;
      o_imem_addr <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!i_flush && (r_count < FULL)) begin
            o_imem_addr <= i_pc;
            o_imem_req  <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_ack) begin
            o_imem_req <= 1'b0;
            r_state    <= S_IDLE;
          end else if (i_flush) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (i_imem_ack) begin
            o_imem_req <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          o_imem_req <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; a flush empties the queue outright.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CONE;
        2'b01:   r_count <= r_count - CONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: returned word tagged with the address it was fetched from.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_q_pc[r_wptr]  <= o_imem_addr;
      r_q_ins[r_wptr] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: PC register and memory models around ifetch_unit,
// with a scoreboard of expected fetch-queue entries.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [31:0] i_pc = '0;
  logic        o_pcwr;
  logic        i_flush = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
  logic        i_id_ready = 1'b0;

  always #5 clk = ~clk;

  ifetch_unit #(.DEPTH(2)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_pc        (i_pc),
    .o_pcwr      (o_pcwr),
    .i_flush     (i_flush),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .i_imem_ack  (i_imem_ack),
    .i_imem_rdata(i_imem_rdata),
    .o_if_valid  (o_if_valid),
    .o_if_instr  (o_if_instr),
    .o_if_pc     (o_if_pc),
    .i_id_ready  (i_id_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  int checks = 0;
  int errors = 0;

  ent_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];

  int          lat = 1;
  int          mem_cnt = 0;
  bit          drop = 1'b0;
  logic        p_pcwr = 1'b0;
  logic        p_rst = 1'b0;
  logic        p_flush = 1'b0;
  logic [31:0] tgt = '0;

  logic        t_pcwr, t_req, t_valid, t_ack;
  logic [31:0] t_addr, t_ifpc, t_ifins;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdata(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick();
    ent_t e;
    if (p_pcwr)
      i_pc = p_rst ? 32'h3000 : (p_flush ? tgt : i_pc + 32'd4);
    if (o_imem_req) begin
      mem_cnt++;
      if (mem_cnt == 1) req_log.push_back(o_imem_addr);
    end else begin
      mem_cnt = 0;
    end
    i_imem_ack   = o_imem_req && (mem_cnt >= lat);
    i_imem_rdata = i_imem_ack ? mdata(o_imem_addr) : 32'h0;
    #1;
    t_pcwr  = o_pcwr;
    t_req   = o_imem_req;
    t_valid = o_if_valid;
    t_ack   = i_imem_ack;
    t_addr  = o_imem_addr;
    t_ifpc  = o_if_pc;
    t_ifins = o_if_instr;
    if (i_rst || i_flush) begin
      exp_q.delete();
    end else begin
      if (o_if_valid && i_id_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_pc", o_if_pc, e.pc);
          chk("sb_ins", o_if_instr, e.ins);
          pop_log.push_back(o_if_pc);
        end
      end
      if (i_imem_ack && !drop)
        exp_q.push_back('{o_imem_addr, i_imem_rdata});
    end
    if (i_rst || i_imem_ack) drop = 1'b0;
    else if (i_flush && o_imem_req) drop = 1'b1;
    if (i_rst) begin
      req_log.delete();
      pop_log.delete();
    end
    p_pcwr  = o_pcwr;
    p_rst   = i_rst;
    p_flush = i_flush;
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_flush    = 1'b0;
    i_id_ready = 1'b0;
    i_rst      = 1'b1;
    tick();
    chk("rst_pcwr0", 32'(t_pcwr), 32'd1);
    tick();
    chk("rst_pcwr1", 32'(t_pcwr), 32'd1);
    chk("rst_req", 32'(t_req), 32'd0);
    chk("rst_valid", 32'(t_valid), 32'd0);
    chk("rst_ifpc", t_ifpc, 32'h0);
    chk("rst_ifins", t_ifins, 32'h0);
    i_rst = 1'b0;
  endtask

  task automatic wait_req(string tag, int n, int budget);
    for (int i = 0; i < budget && req_log.size() < n; i++) tick();
    chk(tag, 32'(req_log.size()), 32'(n));
  endtask

  task automatic wait_pop(string tag, int n, int budget);
    for (int i = 0; i < budget && pop_log.size() < n; i++) tick();
    chk(tag, 32'(pop_log.size()), 32'(n));
  endtask

  initial begin
    @(negedge clk);

    // reset and streaming with zero-wait memory
    do_reset();
    lat = 1;
    i_id_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) chk("str_pc0", i_pc, 32'h3000);
      if (k == 1) chk("str_addr0", t_addr, 32'h3000);
      if (k == 2) chk("str_ins0", t_ifins, mdata(32'h3000));
      chk("str_valid", 32'(t_valid), 32'((k >= 2) && (k % 2 == 0)));
    end
    chk("str_npop", 32'(pop_log.size()), 32'd3);
    chk("str_pop0", pop_log[0], 32'h3000);
    chk("str_pop1", pop_log[1], 32'h3004);
    chk("str_pop2", pop_log[2], 32'h3008);

    // backpressure with a full queue
    do_reset();
    lat = 1;
    i_id_ready = 1'b0;
    repeat (10) tick();
    chk("bp_nreq", 32'(req_log.size()), 32'd2);
    chk("bp_req0", req_log[0], 32'h3000);
    chk("bp_req1", req_log[1], 32'h3004);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_req_low", 32'(t_req), 32'd0);
      chk("bp_pcwr_low", 32'(t_pcwr), 32'd0);
    end
    i_id_ready = 1'b1;
    tick();
    chk("bp_pop_pc", t_ifpc, 32'h3000);
    i_id_ready = 1'b0;
    wait_req("bp_to_req3", 3, 10);
    chk("bp_req2", req_log[2], 32'h3008);

    // flush in the second wait cycle of a slow fetch
    do_reset();
    lat = 3;
    i_id_ready = 1'b0;
    wait_req("fw_to_req2", 2, 20);
    i_flush = 1'b1;
    tgt = 32'h4000;
    tick();
    chk("fw_pcwr_flush", 32'(t_pcwr), 32'd1);
    chk("fw_ack_early", 32'(t_ack), 32'd0);
    i_flush = 1'b0;
    tick();
    chk("fw_drop_req", 32'(t_req), 32'd1);
    chk("fw_drop_ack", 32'(t_ack), 32'd1);
    chk("fw_drop_pcwr", 32'(t_pcwr), 32'd0);
    chk("fw_empty", 32'(t_valid), 32'd0);
    tick();
    chk("fw_empty2", 32'(t_valid), 32'd0);
    wait_req("fw_to_req3", 3, 20);
    chk("fw_req_tgt", req_log[2], 32'h4000);
    i_id_ready = 1'b1;
    wait_pop("fw_to_pop", 1, 20);
    chk("fw_pop_tgt", pop_log[0], 32'h4000);

    // flush coinciding with ack
    do_reset();
    lat = 1;
    i_id_ready = 1'b0;
    repeat (3) tick();
    i_flush = 1'b1;
    tgt = 32'h5000;
    i_id_ready = 1'b1;
    tick();
    chk("fa_ack", 32'(t_ack), 32'd1);
    chk("fa_addr", t_addr, 32'h3004);
    chk("fa_pcwr", 32'(t_pcwr), 32'd1);
    i_flush = 1'b0;
    i_id_ready = 1'b0;
    tick();
    chk("fa_empty", 32'(t_valid), 32'd0);
    chk("fa_nopop", 32'(pop_log.size()), 32'd0);
    i_id_ready = 1'b1;
    wait_req("fa_to_req3", 3, 10);
    chk("fa_req_tgt", req_log[2], 32'h5000);
    wait_pop("fa_to_pop", 1, 20);
    chk("fa_pop_tgt", pop_log[0], 32'h5000);

    // reset while a request is outstanding
    do_reset();
    lat = 3;
    i_id_ready = 1'b1;
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    chk("rm_pcwr", 32'(t_pcwr), 32'd1);
    i_rst = 1'b0;
    tick();
    chk("rm_req", 32'(t_req), 32'd0);
    chk("rm_valid", 32'(t_valid), 32'd0);
    wait_req("rm_to_req", 1, 10);
    chk("rm_restart", req_log[0], 32'h3000);
    wait_pop("rm_to_pop", 1, 20);
    chk("rm_pop", pop_log[0], 32'h3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage placed directly downstream of the PC register. Each cycle it decides whether to fetch the instruction at the current `pc`, runs a req/ack handshake with instruction memory, and buffers returned instructions with their addresses in a small queue feeding decode. It owns the PC write enable `pcwr`, advancing the PC only when a fetch completes or a redirect (flush) occurs. It also asserts `pcwr` during reset so the PC's reset can take effect.

## Interface
- `DEPTH`, 2, fetch queue entries; a power of two, ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  32  current instruction address from the PC register.
- `pcwr`  out  1  PC write enable; combinational.
- `flush`  in  1  redirect; `npc` holds the target this cycle.
- `imem_req`  out  1  memory request; registered.
- `imem_addr`  out  32  request address; registered, stable while `imem_req` is high.
- `imem_ack`  in  1  single-cycle completion; only asserted while `imem_req` is high.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack` is high.
- `if_valid`  out  1  queue non-empty.
- `if_instr`  out  32  head-entry instruction.
- `if_pc`  out  32  head-entry address.
- `id_ready`  in  1  decode accepts the head entry.

## Operation
- **State machine.** There are three states.
  - IDLE: no request is outstanding.
  - WAIT: a request is outstanding and its data will be kept.
  - DROP: a request is outstanding and its data will be discarded.
- **Reset.**
  - State goes to IDLE; queue count goes to 0; `imem_req`=0; `imem_addr`=0.
  - `if_valid`=0; `if_instr`=0 and `if_pc`=0 while the queue is empty.
  - `pcwr`=1 for the whole time `rst` is high.
- **IDLE.**
  - Issue when `!flush` and count < DEPTH: latch `imem_addr`←`pc`, set `imem_req`←1, go to WAIT.
  - With `flush`: stay in IDLE and issue nothing.
- **WAIT.**
  - `imem_ack` with no `flush`: push {`imem_addr`, `imem_rdata`} into the queue, set `imem_req`←0, go to IDLE.
  - `imem_ack` with `flush`: discard the data, set `imem_req`←0, go to IDLE.
  - `flush` without `imem_ack`: go to DROP; `imem_req` stays high.
  - Otherwise: hold.
- **DROP.**
  - On `imem_ack`: discard the data, set `imem_req`←0, go to IDLE.
  - `flush` in DROP: no extra effect.
- **`pcwr` equation.** `pcwr` = `rst` | `flush` | (WAIT & `imem_ack`). It is never asserted in DROP except through `flush` or `rst`.
- **Queue.**
  - FIFO with DEPTH entries and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
  - Pop when `if_valid` & `id_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - A push never finds the queue full: only one request is ever outstanding, and issue requires count < DEPTH.
- **Flush precedence.** `flush` empties the queue at that edge, overriding any pop or push.
- **Reset mid-operation.** `rst` takes effect even with a request outstanding; any later `imem_ack` is not expected and is ignored in IDLE.

## Timing
- **Issue.**
  - Decision in IDLE in cycle N.
  - `imem_req` and `imem_addr` are visible in cycle N+1.
  - Earliest `imem_ack` is in cycle N+1.
- **Completion.**
  - The push and PC advance happen at the end of the ack cycle.
  - `if_valid` rises the cycle after the ack.
  - The new `pc` is visible in the next IDLE cycle.
- **Throughput.** At best one instruction every 2 cycles with zero-wait memory.
- **Backpressure.** When count = DEPTH in IDLE, no request is issued and `pcwr` stays 0 until a pop lowers the count.
- **Redirect.** The target appears on `pc` the cycle after `flush`, and the first post-flush request uses that `pc`.

## Test plan
- **Reset.** Hold `rst` for 2 cycles.
  - During reset: `pcwr`=1, `imem_req`=0, `if_valid`=0.
  - After release, the PC reads 0x0000_3000; first `imem_addr`=0x0000_3000.
- **Streaming.** Zero-wait memory acks on the first req cycle; `id_ready`=1.
  - `if_pc` sequence 0x3000, 0x3004, 0x3008, with `if_valid` high every other cycle.
  - `if_instr` matches the memory model.
- **Backpressure.** `id_ready`=0 with DEPTH=2.
  - Exactly two requests (0x3000, 0x3004); then `imem_req`=0 and `pcwr`=0 indefinitely.
  - Raising `id_ready` for 1 cycle pops 0x3000, and the next request goes to 0x3008.
- **Flush while waiting.** Memory has a 3-cycle latency; `flush` with target 0x4000 arrives in the second WAIT cycle.
  - State goes to DROP; the 0x3004 response is discarded and the queue is empty.
  - The next request is 0x4000, and the next `if_pc` is 0x4000.
- **Flush with ack in the same cycle.** `flush` coincides with `imem_ack`.
  - No push; `pcwr`=1; the next `imem_addr` is the target.
  - A queued entry that `id_ready` would have popped is gone.
- **Reset mid-request.** Assert `rst` in WAIT.
  - Next cycle: IDLE, `imem_req`=0, `if_valid`=0.
  - The fetch restarts at 0x0000_3000.
